axi_rd_arbiter: RTL and testbench

- Shares the single AR/R read port of the dram model between two read requesters.
- Port 0 carries demand reads from the core; port 1 carries prefetch reads from the prefetcher.
- Arbitration gives demand priority, with a starvation guard for prefetch. AR requests are registered onto one master port.
- R beats are routed back in order using an internal route FIFO. The dram model returns bursts in AR-acceptance order.

---
 rtl/axi_rd_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AR/R read port of the dram model between two requesters.
//   s0 : demand reads from the core (normally wins arbitration)
//   s1 : prefetch reads from the prefetcher (forced through after
//        STARVE_LIMIT consecutive demand wins while it waits)
//
// The winning AR request is registered onto the master port. Every
// requester handshake pushes the source index into a small route FIFO.
// Returning R beats go to the requester at the FIFO head, and the entry is
// popped on the last beat. The dram model returns bursts in AR-acceptance
// order, so order alone decides routing; IDs pass through untouched.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s0_ar_* / s1_ar_*         requester AR channels (valid/ready/addr/len/id)
//   s0_r_*  / s1_r_*          requester R channels (data/id/resp/last broadcast)
//   m_ar_*                    registered AR channel towards the dram
//   m_r_*                     R channel from the dram
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int LOG_OUTSTANDING = 2,
    parameter int STARVE_WIDTH    = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    // demand requester
    input  logic                       s0_ar_valid,
    output logic                       s0_ar_ready,
    input  logic [ADDR_WIDTH-1:0]      s0_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] s0_ar_len,
    input  logic [ID_WIDTH-1:0]        s0_ar_id,
    output logic                       s0_r_valid,
    input  logic                       s0_r_ready,
    output logic [DATA_WIDTH-1:0]      s0_r_data,
    output logic [ID_WIDTH-1:0]        s0_r_id,
    output logic [1:0]                 s0_r_resp,
    output logic                       s0_r_last,
    // prefetch requester
    input  logic                       s1_ar_valid,
    output logic                       s1_ar_ready,
    input  logic [ADDR_WIDTH-1:0]      s1_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] s1_ar_len,
    input  logic [ID_WIDTH-1:0]        s1_ar_id,
    output logic                       s1_r_valid,
    input  logic                       s1_r_ready,
    output logic [DATA_WIDTH-1:0]      s1_r_data,
    output logic [ID_WIDTH-1:0]        s1_r_id,
    output logic [1:0]                 s1_r_resp,
    output logic                       s1_r_last,
    // master port to the dram
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_WIDTH-1:0]      m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [ID_WIDTH-1:0]        m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic [ID_WIDTH-1:0]        m_r_id,
    input  logic [1:0]                 m_r_resp,
    input  logic                       m_r_last
);

    localparam int DEPTH = 1 << LOG_OUTSTANDING;
    localparam int CNT_W = LOG_OUTSTANDING + 1;

    localparam logic [CNT_W-1:0]           DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1'b1);
    localparam logic [LOG_OUTSTANDING-1:0] PTR_ONE    = LOG_OUTSTANDING'(1'b1);
    localparam logic [STARVE_WIDTH-1:0]    STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_WIDTH-1:0]    STARVE_ONE = STARVE_WIDTH'(1'b1);

    // AR output register
    logic                       m_ar_valid_r;
    logic [ADDR_WIDTH-1:0]      m_ar_addr_r;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len_r;
    logic [ID_WIDTH-1:0]        m_ar_id_r;

    // arbitration
    logic                       load_en_s;
    logic                       gnt0_s;
    logic                       gnt1_s;
    logic                       hs0_s;
    logic                       hs1_s;
    logic [STARVE_WIDTH-1:0]    starve_r;

    // route FIFO: one bit per granted burst, 1 = prefetch
    logic [DEPTH-1:0]           route_mem_r;
    logic [LOG_OUTSTANDING-1:0] wr_ptr_r;
    logic [LOG_OUTSTANDING-1:0] rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       push_s;
    logic                       pop_s;
    logic                       head_s;
    logic                       nonempty_s;

    // R routing
    logic                       s0_r_valid_s;
    logic                       s1_r_valid_s;
    logic                       m_r_ready_s;

    // Grant selection: demand wins unless prefetch has waited STARVE_LIMIT wins.
    always_comb begin
        load_en_s = 1'b0;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        hs0_s     = 1'b0;
        hs1_s     = 1'b0;
        if (!rst && (!m_ar_valid_r || m_ar_ready) && (count_r < DEPTH_C)) begin
            load_en_s = 1'b1;
        end else begin
            load_en_s = 1'b0;
        end
        gnt1_s = s1_ar_valid && (!s0_ar_valid || (starve_r == STARVE_MAX));
        gnt0_s = s0_ar_valid && !gnt1_s;
        hs0_s  = load_en_s && gnt0_s;
        hs1_s  = load_en_s && gnt1_s;
    end

    assign s0_ar_ready = hs0_s;
    assign s1_ar_ready = hs1_s;

    // AR register: load the winner, otherwise drop valid once the dram takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_ar_valid_r <= 1'b0;
            m_ar_addr_r  <= {ADDR_WIDTH{1'b0}};
            m_ar_len_r   <= {BURST_LEN_WIDTH{1'b0}};
            m_ar_id_r    <= {ID_WIDTH{1'b0}};
        end else if (hs0_s) begin
            m_ar_valid_r <= 1'b1;
            m_ar_addr_r  <= s0_ar_addr;
            m_ar_len_r   <= s0_ar_len;
            m_ar_id_r    <= s0_ar_id;
        end else if (hs1_s) begin
            m_ar_valid_r <= 1'b1;
            m_ar_addr_r  <= s1_ar_addr;
            m_ar_len_r   <= s1_ar_len;
            m_ar_id_r    <= s1_ar_id;
        end else if (m_ar_ready) begin
            m_ar_valid_r <= 1'b0;
        end else begin
            m_ar_valid_r <= m_ar_valid_r;
        end
    end

    assign m_ar_valid = m_ar_valid_r;
    assign m_ar_addr  = m_ar_addr_r;
    assign m_ar_len   = m_ar_len_r;
    assign m_ar_id    = m_ar_id_r;

    // Starvation counter: counts demand wins that bypassed a waiting prefetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= {STARVE_WIDTH{1'b0}};
        end else if (hs1_s) begin
            starve_r <= {STARVE_WIDTH{1'b0}};
        end else if (hs0_s && s1_ar_valid && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + STARVE_ONE;
        end else begin
            starve_r <= starve_r;
        end
    end

    assign push_s = hs0_s || hs1_s;
    assign pop_s  = m_r_valid && m_r_ready_s && m_r_last;

    // Route FIFO: remember the source of every grant until its last R beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            route_mem_r <= {DEPTH{1'b0}};
            wr_ptr_r    <= {LOG_OUTSTANDING{1'b0}};
            rd_ptr_r    <= {LOG_OUTSTANDING{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                route_mem_r[wr_ptr_r] <= hs1_s;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // With nothing outstanding, no beat can belong to anyone: hold the dram off.
    assign head_s     = route_mem_r[rd_ptr_r];
    assign nonempty_s = (count_r != {CNT_W{1'b0}}) && !rst;

    // R routing: steer valid to the head source and take ready from it.
    always_comb begin
        s0_r_valid_s = 1'b0;
        s1_r_valid_s = 1'b0;
        m_r_ready_s  = 1'b0;
        if (nonempty_s) begin
            if (head_s) begin
                s1_r_valid_s = m_r_valid;
                m_r_ready_s  = s1_r_ready;
            end else begin
                s0_r_valid_s = m_r_valid;
                m_r_ready_s  = s0_r_ready;
            end
        end else begin
            s0_r_valid_s = 1'b0;
            s1_r_valid_s = 1'b0;
            m_r_ready_s  = 1'b0;
        end
    end

    assign s0_r_valid = s0_r_valid_s;
    assign s1_r_valid = s1_r_valid_s;
    assign m_r_ready  = m_r_ready_s;

    assign s0_r_data = m_r_data;
    assign s0_r_id   = m_r_id;
    assign s0_r_resp = m_r_resp;
    assign s0_r_last = m_r_last;
    assign s1_r_data = m_r_data;
    assign s1_r_id   = m_r_id;
    assign s1_r_resp = m_r_resp;
    assign s1_r_last = m_r_last;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed bench for axi_rd_arbiter with a small in-order dram model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s0_ar_valid = 1'b0, s1_ar_valid = 1'b0;
    logic        s0_ar_ready, s1_ar_ready;
    logic [15:0] s0_ar_addr = 16'h0, s1_ar_addr = 16'h0;
    logic [7:0]  s0_ar_len = 8'h0, s1_ar_len = 8'h0;
    logic [7:0]  s0_ar_id = 8'h0, s1_ar_id = 8'h0;
    logic        s0_r_valid, s1_r_valid;
    logic        s0_r_ready = 1'b1, s1_r_ready = 1'b1;
    logic [31:0] s0_r_data, s1_r_data;
    logic [7:0]  s0_r_id, s1_r_id;
    logic [1:0]  s0_r_resp, s1_r_resp;
    logic        s0_r_last, s1_r_last;

    logic        m_ar_valid, m_ar_ready;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id;
    logic        m_r_valid, m_r_ready;
    logic [31:0] m_r_data;
    logic [7:0]  m_r_id;
    logic [1:0]  m_r_resp;
    logic        m_r_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
        .s0_ar_len(s0_ar_len), .s0_ar_id(s0_ar_id),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(s0_r_data),
        .s0_r_id(s0_r_id), .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
        .s1_ar_len(s1_ar_len), .s1_ar_id(s1_ar_id),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(s1_r_data),
        .s1_r_id(s1_r_id), .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_id(m_r_id), .m_r_resp(m_r_resp), .m_r_last(m_r_last)
    );

    // ---------------- dram model: in-order bursts, data = {D0, id, addr+beat}
    logic [15:0] mq_addr [0:63];
    logic [7:0]  mq_len  [0:63];
    logic [7:0]  mq_id   [0:63];
    logic [5:0]  mq_wr = 6'd0, mq_rd = 6'd0;
    logic [7:0]  beat = 8'd0;
    logic        r_en = 1'b0;
    logic        ar_rdy = 1'b1;

    assign m_ar_ready = ar_rdy;
    assign m_r_valid  = r_en && (mq_wr != mq_rd);
    assign m_r_id     = mq_id[mq_rd];
    assign m_r_last   = (beat == mq_len[mq_rd]);
    assign m_r_resp   = 2'b00;
    assign m_r_data   = {8'hD0, mq_id[mq_rd], mq_addr[mq_rd] + {8'h00, beat}};

    // dram model state: capture accepted ARs, step through beats
    always @(posedge clk) begin
        if (rst) begin
            mq_wr <= 6'd0;
            mq_rd <= 6'd0;
            beat  <= 8'd0;
        end else begin
            if (m_ar_valid && m_ar_ready) begin
                mq_addr[mq_wr] <= m_ar_addr;
                mq_len[mq_wr]  <= m_ar_len;
                mq_id[mq_wr]   <= m_ar_id;
                mq_wr          <= mq_wr + 6'd1;
            end
            if (m_r_valid && m_r_ready) begin
                if (m_r_last) begin
                    beat  <= 8'd0;
                    mq_rd <= mq_rd + 6'd1;
                end else begin
                    beat <= beat + 8'd1;
                end
            end
        end
    end

    // ---------------- helpers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
        s0_ar_addr = 16'h0; s0_ar_len = 8'h0; s0_ar_id = 8'h0;
        s1_ar_addr = 16'h0; s1_ar_len = 8'h0; s1_ar_id = 8'h0;
        s0_r_ready = 1'b1; s1_r_ready = 1'b1;
        r_en = 1'b0; ar_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; s0_ar_valid = 1'b1; s1_ar_valid = 1'b1; r_en = 1'b1;
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b0) begin n_err++; $display("FAIL rst_s0_ar_ready got=%b exp=0", s0_ar_ready); end
        n_cmp++; if (s1_ar_ready !== 1'b0) begin n_err++; $display("FAIL rst_s1_ar_ready got=%b exp=0", s1_ar_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (m_ar_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_ar_valid got=%b exp=0", m_ar_valid); end
        n_cmp++; if ({m_ar_addr, m_ar_len, m_ar_id} !== 32'h0) begin n_err++; $display("FAIL rst_m_ar_fields got=%h exp=0", {m_ar_addr, m_ar_len, m_ar_id}); end
        n_cmp++; if (m_r_ready !== 1'b0) begin n_err++; $display("FAIL rst_m_r_ready got=%b exp=0", m_r_ready); end
        n_cmp++; if ({s0_r_valid, s1_r_valid} !== 2'b00) begin n_err++; $display("FAIL rst_s_r_valid got=%b exp=00", {s0_r_valid, s1_r_valid}); end
    endtask

    task automatic test_demand_only();
        int k;
        logic s1_seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s0_ar_valid = 1'b1; s0_ar_addr = 16'(16 * (i + 1)); s0_ar_len = 8'd3; s0_ar_id = 8'(i + 1);
            #1;
            n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== 2'b10) begin n_err++; $display("FAIL demand_ready_%0d got=%b exp=10", i, {s0_ar_ready, s1_ar_ready}); end
            @(negedge clk);
            n_cmp++; if ({m_ar_valid, m_ar_addr, m_ar_len, m_ar_id} !== {1'b1, 16'(16 * (i + 1)), 8'd3, 8'(i + 1)}) begin
                n_err++; $display("FAIL demand_m_ar_%0d got=%b/%h/%h/%h exp=1/%h/03/%h", i, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, 16'(16 * (i + 1)), 8'(i + 1));
            end
        end
        s0_ar_valid = 1'b0;
        r_en = 1'b1;
        k = 0;
        s1_seen = 1'b0;
        for (int c = 0; c < 60 && k < 12; c++) begin
            #1;
            if (s1_r_valid) s1_seen = 1'b1;
            if (s0_r_valid) begin
                n_cmp++; if (s0_r_id !== 8'(k / 4 + 1)) begin n_err++; $display("FAIL demand_r_id_%0d got=%h exp=%h", k, s0_r_id, 8'(k / 4 + 1)); end
                n_cmp++; if (s0_r_last !== ((k % 4) == 3)) begin n_err++; $display("FAIL demand_r_last_%0d got=%b exp=%b", k, s0_r_last, (k % 4) == 3); end
                k++;
            end
            @(negedge clk);
        end
        n_cmp++; if (k != 12) begin n_err++; $display("FAIL demand_beat_count got=%0d exp=12", k); end
        n_cmp++; if (s1_seen !== 1'b0) begin n_err++; $display("FAIL demand_s1_r_valid got=%b exp=0", s1_seen); end
    endtask

    task automatic test_starvation();
        logic exp1;
        do_reset();
        r_en = 1'b1;
        s0_ar_valid = 1'b1; s0_ar_addr = 16'h1000; s0_ar_len = 8'd0; s0_ar_id = 8'hA0;
        s1_ar_valid = 1'b1; s1_ar_addr = 16'h2000; s1_ar_len = 8'd0; s1_ar_id = 8'hB0;
        for (int c = 0; c < 18; c++) begin
            #1;
            exp1 = ((c % 9) == 8);
            n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== {!exp1, exp1}) begin n_err++; $display("FAIL starve_grant_c%0d got=%b exp=%b", c, {s0_ar_ready, s1_ar_ready}, {!exp1, exp1}); end
            if (s0_r_valid) begin
                n_cmp++; if (s0_r_id !== 8'hA0) begin n_err++; $display("FAIL starve_s0_r_id_c%0d got=%h exp=a0", c, s0_r_id); end
            end
            if (s1_r_valid) begin
                n_cmp++; if (s1_r_id !== 8'hB0) begin n_err++; $display("FAIL starve_s1_r_id_c%0d got=%h exp=b0", c, s1_r_id); end
            end
            @(negedge clk);
        end
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
    endtask

    task automatic test_outstanding();
        do_reset();
        s0_ar_valid = 1'b1; s0_ar_addr = 16'h0400; s0_ar_len = 8'd0; s0_ar_id = 8'h40;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++; if (s0_ar_ready !== (c < 4)) begin n_err++; $display("FAIL outst_ready_c%0d got=%b exp=%b", c, s0_ar_ready, c < 4); end
            @(negedge clk);
        end
        r_en = 1'b1;
        #1;
        n_cmp++; if ({s0_r_valid, m_r_ready, s0_ar_ready} !== 3'b110) begin n_err++; $display("FAIL outst_pop_cycle got=%b exp=110", {s0_r_valid, m_r_ready, s0_ar_ready}); end
        @(negedge clk);
        r_en = 1'b0;
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL outst_reaccept got=%b exp=1", s0_ar_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b0) begin n_err++; $display("FAIL outst_refull got=%b exp=0", s0_ar_ready); end
        s0_ar_valid = 1'b0;
    endtask

    task automatic test_interleave();
        do_reset();
        s1_ar_valid = 1'b1; s1_ar_addr = 16'h0100; s1_ar_len = 8'd1; s1_ar_id = 8'h11;
        #1;
        n_cmp++; if (s1_ar_ready !== 1'b1) begin n_err++; $display("FAIL ilv_gnt_a got=%b exp=1", s1_ar_ready); end
        @(negedge clk);
        s1_ar_valid = 1'b0;
        s0_ar_valid = 1'b1; s0_ar_addr = 16'h0200; s0_ar_len = 8'd0; s0_ar_id = 8'h22;
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL ilv_gnt_b got=%b exp=1", s0_ar_ready); end
        @(negedge clk);
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b1; s1_ar_addr = 16'h0300; s1_ar_len = 8'd2; s1_ar_id = 8'h33;
        #1;
        n_cmp++; if (s1_ar_ready !== 1'b1) begin n_err++; $display("FAIL ilv_gnt_c got=%b exp=1", s1_ar_ready); end
        @(negedge clk);
        s1_ar_valid = 1'b0;
        s0_r_ready = 1'b0;
        @(negedge clk);
        r_en = 1'b1;
        for (int b = 0; b < 2; b++) begin
            #1;
            n_cmp++; if ({s1_r_valid, s0_r_valid, s1_r_id, s1_r_last} !== {2'b10, 8'h11, b == 1}) begin
                n_err++; $display("FAIL ilv_s1_first_%0d got=%b%b/%h/%b exp=10/11/%b", b, s1_r_valid, s0_r_valid, s1_r_id, s1_r_last, b == 1);
            end
            n_cmp++; if (s1_r_data !== (32'hD011_0100 + 32'(b))) begin n_err++; $display("FAIL ilv_s1_data_%0d got=%h exp=%h", b, s1_r_data, 32'hD011_0100 + 32'(b)); end
            @(negedge clk);
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if ({s0_r_valid, s1_r_valid, m_r_ready, s0_r_id} !== {3'b100, 8'h22}) begin
                n_err++; $display("FAIL ilv_s0_stall_%0d got=%b%b%b/%h exp=100/22", c, s0_r_valid, s1_r_valid, m_r_ready, s0_r_id);
            end
            if (c == 1) begin
                s0_r_ready = 1'b1;
                #1;
                n_cmp++; if (m_r_ready !== 1'b1) begin n_err++; $display("FAIL ilv_s0_release got=%b exp=1", m_r_ready); end
            end
            @(negedge clk);
        end
        for (int b = 0; b < 3; b++) begin
            #1;
            n_cmp++; if ({s1_r_valid, s0_r_valid, s1_r_id, s1_r_last} !== {2'b10, 8'h33, b == 2}) begin
                n_err++; $display("FAIL ilv_s1_second_%0d got=%b%b/%h/%b exp=10/33/%b", b, s1_r_valid, s0_r_valid, s1_r_id, s1_r_last, b == 2);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if ({s0_r_valid, s1_r_valid, m_r_ready} !== 3'b000) begin n_err++; $display("FAIL ilv_drained got=%b exp=000", {s0_r_valid, s1_r_valid, m_r_ready}); end
    endtask

    task automatic test_ar_backpressure();
        do_reset();
        ar_rdy = 1'b0;
        s0_ar_valid = 1'b1; s0_ar_addr = 16'h0040; s0_ar_len = 8'd2; s0_ar_id = 8'h05;
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_gnt got=%b exp=1", s0_ar_ready); end
        @(negedge clk);
        s0_ar_addr = 16'h0050; s0_ar_id = 8'h06;
        s1_ar_valid = 1'b1; s1_ar_addr = 16'h0060; s1_ar_id = 8'h07;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if ({m_ar_valid, m_ar_addr, m_ar_len, m_ar_id} !== {1'b1, 16'h0040, 8'd2, 8'h05}) begin
                n_err++; $display("FAIL bp_stable_%0d got=%b/%h/%h/%h exp=1/0040/02/05", c, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id);
            end
            n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready_%0d got=%b exp=00", c, {s0_ar_ready, s1_ar_ready}); end
            @(negedge clk);
        end
        ar_rdy = 1'b1;
        #1;
        n_cmp++; if ({s0_ar_ready, s1_ar_ready} !== 2'b10) begin n_err++; $display("FAIL bp_regrant got=%b exp=10", {s0_ar_ready, s1_ar_ready}); end
        @(negedge clk);
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
        #1;
        n_cmp++; if ({m_ar_addr, m_ar_id} !== {16'h0050, 8'h06}) begin n_err++; $display("FAIL bp_next_ar got=%h/%h exp=0050/06", m_ar_addr, m_ar_id); end
        n_cmp++; if ({mq_wr, mq_addr[0]} !== {6'd1, 16'h0040}) begin n_err++; $display("FAIL bp_dram_got got=%0d/%h exp=1/0040", mq_wr, mq_addr[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        s0_ar_valid = 1'b1; s0_ar_addr = 16'h0070; s0_ar_len = 8'd1; s0_ar_id = 8'h08;
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL mid_gnt_a got=%b exp=1", s0_ar_ready); end
        @(negedge clk);
        s0_ar_addr = 16'h0078; s0_ar_id = 8'h09;
        #1;
        n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL mid_gnt_b got=%b exp=1", s0_ar_ready); end
        @(negedge clk);
        s1_ar_valid = 1'b1;
        #1;
        n_cmp++; if (m_ar_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_m_ar_valid got=%b exp=1", m_ar_valid); end
        rst = 1'b1; r_en = 1'b1;
        #1;
        n_cmp++; if ({s0_ar_ready, s1_ar_ready, m_r_ready} !== 3'b000) begin n_err++; $display("FAIL mid_in_rst got=%b exp=000", {s0_ar_ready, s1_ar_ready, m_r_ready}); end
        @(negedge clk);
        #1;
        n_cmp++; if ({m_ar_valid, m_r_ready, s0_r_valid, s1_r_valid, s0_ar_ready, s1_ar_ready} !== 6'b0) begin
            n_err++; $display("FAIL mid_after_rst got=%b exp=000000", {m_ar_valid, m_r_ready, s0_r_valid, s1_r_valid, s0_ar_ready, s1_ar_ready});
        end
        rst = 1'b0;
        #1;
        n_cmp++; if ({s0_ar_ready, s1_ar_ready, s0_r_valid, m_r_ready} !== 4'b1000) begin
            n_err++; $display("FAIL mid_resume got=%b exp=1000", {s0_ar_ready, s1_ar_ready, s0_r_valid, m_r_ready});
        end
        @(negedge clk);
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
        #1;
        n_cmp++; if ({m_ar_valid, m_ar_id} !== {1'b1, 8'h09}) begin n_err++; $display("FAIL mid_resume_ar got=%b/%h exp=1/09", m_ar_valid, m_ar_id); end
    endtask

    // watchdog: every loop above is bounded, this only guards against a hang
    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

    // test sequence
    initial begin
        test_reset();
        test_demand_only();
        test_starvation();
        test_outstanding();
        test_interleave();
        test_ar_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
